// File: rtl/branch_redirect.sv
// Decode-stage branch resolver: evaluates the branch condition, computes the
// target and holds a redirect request for fetch until it is accepted, while
// keeping taken / not-taken statistics.
module branch_redirect #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             BranchValidD,
    input  logic [2:0]       BranchOpD,
    input  logic [31:0]      RsValD,
    input  logic [31:0]      RtValD,
    input  logic [31:0]      PCPlus4D,
    input  logic [31:0]      SignImmD_shift2,
    input  logic             FlushD,
    input  logic             RedirectReady,
    output logic             BranchReadyD,
    output logic             RedirectValid,
    output logic [31:0]      RedirectPC,
    output logic [CNT_W-1:0] TakenCnt,
    output logic [CNT_W-1:0] NotTakenCnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  taken_q, taken_d;
    logic [CNT_W-1:0]  not_taken_q, not_taken_d;
    logic              cond;
    logic              accept;
    logic [XLEN-1:0]   target;

    // Ready when idle, or when the pending redirect is consumed this cycle.
    assign BranchReadyD = (state_q == IDLE) || RedirectReady;
    assign accept       = BranchValidD && BranchReadyD && !FlushD && (BranchOpD != 3'b000);
    assign target       = XLEN'(PCPlus4D + SignImmD_shift2);

    assign RedirectValid = (state_q == PENDING);
    assign RedirectPC    = pc_q;
    assign TakenCnt      = taken_q;
    assign NotTakenCnt   = not_taken_q;

    // Branch condition decode.
    always_comb begin
        cond = 1'b0;
        case (BranchOpD)
            3'b001:  cond = (RsValD == RtValD);
            3'b010:  cond = (RsValD != RtValD);
            3'b011:  cond = !RsValD[XLEN-1];
            3'b100:  cond = !RsValD[XLEN-1] && (RsValD != '0);
            3'b101:  cond = RsValD[XLEN-1] || (RsValD == '0);
            3'b110:  cond = RsValD[XLEN-1];
            3'b111:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Next-state, target and counter update; flush dominates everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (FlushD) begin
            state_d = IDLE;
        end else if (accept) begin
            if (cond) begin
                state_d = PENDING;
                pc_d    = target;
                taken_d = taken_q + CNT_W'(1);
            end else begin
                state_d     = IDLE;
                not_taken_d = not_taken_q + CNT_W'(1);
            end
        end else if ((state_q == PENDING) && RedirectReady) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect; a default-width and a 2-bit-counter
// instance share the same stimulus.
module tb_branch_redirect;

    logic        clock;
    logic        reset;
    logic        branch_valid;
    logic [2:0]  branch_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] imm_shift2;
    logic        flush;
    logic        redirect_ready;

    logic        branch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;

    logic        branch_ready_w2;
    logic        redirect_valid_w2;
    logic [31:0] redirect_pc_w2;
    logic [1:0]  taken_cnt_w2;
    logic [1:0]  not_taken_cnt_w2;

    int n_checks = 0;
    int n_fail   = 0;

    branch_redirect dut (
        .clock           (clock),
        .reset           (reset),
        .BranchValidD    (branch_valid),
        .BranchOpD       (branch_op),
        .RsValD          (rs_val),
        .RtValD          (rt_val),
        .PCPlus4D        (pc_plus4),
        .SignImmD_shift2 (imm_shift2),
        .FlushD          (flush),
        .RedirectReady   (redirect_ready),
        .BranchReadyD    (branch_ready),
        .RedirectValid   (redirect_valid),
        .RedirectPC      (redirect_pc),
        .TakenCnt        (taken_cnt),
        .NotTakenCnt     (not_taken_cnt)
    );

    branch_redirect #(.CNT_W(2)) dut_w2 (
        .clock           (clock),
        .reset           (reset),
        .BranchValidD    (branch_valid),
        .BranchOpD       (branch_op),
        .RsValD          (rs_val),
        .RtValD          (rt_val),
        .PCPlus4D        (pc_plus4),
        .SignImmD_shift2 (imm_shift2),
        .FlushD          (flush),
        .RedirectReady   (redirect_ready),
        .BranchReadyD    (branch_ready_w2),
        .RedirectValid   (redirect_valid_w2),
        .RedirectPC      (redirect_pc_w2),
        .TakenCnt        (taken_cnt_w2),
        .NotTakenCnt     (not_taken_cnt_w2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic fl, input logic rdy);
        branch_valid   = v;
        branch_op      = op;
        rs_val         = rs;
        rt_val         = rt;
        pc_plus4       = pc4;
        imm_shift2     = imm;
        flush          = fl;
        redirect_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks registered outputs of both instances against expected values.
    task automatic expect_out(input string tag, input logic rv, input logic [31:0] pc,
                              input int tk, input int nt);
        check({tag, ".rv"},    32'(redirect_valid),     32'(rv));
        check({tag, ".pc"},    redirect_pc,             pc);
        check({tag, ".tk"},    32'(taken_cnt),          32'(tk % 65536));
        check({tag, ".nt"},    32'(not_taken_cnt),      32'(nt % 65536));
        check({tag, ".rv2"},   32'(redirect_valid_w2),  32'(rv));
        check({tag, ".pc2"},   redirect_pc_w2,          pc);
        check({tag, ".tk2"},   32'(taken_cnt_w2),       32'(tk % 4));
        check({tag, ".nt2"},   32'(not_taken_cnt_w2),   32'(nt % 4));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("reset", 1'b0, 32'h0, 0, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(branch_ready), 32'd1);
        tick();

        // BEQ hit
        drive(1'b1, 3'b001, 32'd5, 32'd5, 32'h1000_0004, 32'h0000_0010, 1'b0, 1'b0);
        check("beq.ready", 32'(branch_ready), 32'd1);
        tick();
        expect_out("beq", 1'b1, 32'h1000_0014, 1, 0);

        // Backpressure: BNE presented but not accepted for 3 cycles
        drive(1'b1, 3'b010, 32'd1, 32'd2, 32'h2000_0000, 32'h0000_0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp.ready", 32'(branch_ready), 32'd0);
            tick();
            expect_out("bp.hold", 1'b1, 32'h1000_0014, 1, 0);
        end
        redirect_ready = 1'b1;
        #1;
        check("bp.ready_release", 32'(branch_ready), 32'd1);
        tick();
        expect_out("bne_b2b", 1'b1, 32'h2000_0100, 2, 0);

        // Always-taken with negative offset, back-to-back
        drive(1'b1, 3'b111, '0, '0, 32'h0000_0004, 32'hFFFF_FFF0, 1'b0, 1'b1);
        tick();
        expect_out("wrap", 1'b1, 32'hFFFF_FFF4, 3, 0);

        // BGTZ with Rs=0: not taken, redirect drops, PC held
        drive(1'b1, 3'b100, 32'h0, '0, 32'h0000_0300, 32'h0000_0040, 1'b0, 1'b1);
        tick();
        expect_out("bgtz0", 1'b0, 32'hFFFF_FFF4, 3, 1);

        // Op 000 ignored
        drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_0500, 32'h0000_0008, 1'b0, 1'b0);
        tick();
        expect_out("op_none", 1'b0, 32'hFFFF_FFF4, 3, 1);

        // BLEZ with Rs=0: taken; 2-bit counter wraps to 0
        drive(1'b1, 3'b101, 32'h0, '0, 32'h0000_0100, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        expect_out("blez0", 1'b1, 32'h0000_0120, 4, 1);

        // BLTZ with Rs=0x8000_0000: taken (fifth taken)
        drive(1'b1, 3'b110, 32'h8000_0000, '0, 32'h0000_0200, 32'h0000_0004, 1'b0, 1'b1);
        tick();
        expect_out("bltz_min", 1'b1, 32'h0000_0204, 5, 1);

        // Flush with ready and a taken branch: plain flush
        drive(1'b1, 3'b111, '0, '0, 32'h0000_0900, 32'h0000_0010, 1'b1, 1'b1);
        tick();
        expect_out("flush", 1'b0, 32'h0000_0204, 5, 1);
        drive(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
        check("flush.ready", 32'(branch_ready), 32'd1);

        // BEQ miss
        drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h0000_0A00, 32'h0000_0010, 1'b0, 1'b0);
        tick();
        expect_out("beq_miss", 1'b0, 32'h0000_0204, 5, 2);

        // BGEZ with max positive: taken
        drive(1'b1, 3'b011, 32'h7FFF_FFFF, '0, 32'h0000_1000, 32'h0000_0008, 1'b0, 1'b0);
        tick();
        expect_out("bgez", 1'b1, 32'h0000_1008, 6, 2);

        // Reset mid-PENDING overrides an acceptance in the same cycle
        drive(1'b1, 3'b111, '0, '0, 32'h0000_2000, 32'h0000_0010, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        expect_out("reset_pending", 1'b0, 32'h0, 0, 0);
        reset = 1'b0;
        drive(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
        check("ready_after_reset2", 32'(branch_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of each branch statistics counter.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 BranchValidD  input  1  decode stage presents a branch this cycle.
REQ-006 BranchOpD  input  3  branch condition code, defined in REQ-014.
REQ-007 RsValD  input  32  forwarded rs operand.
REQ-008 RtValD  input  32  forwarded rt operand.
REQ-009 PCPlus4D  input  32  PC of the branch plus 4.
REQ-010 SignImmD_shift2  input  32  sign-extended immediate shifted left by 2, supplied by the immediate shifter.
REQ-011 FlushD  input  1  kills the pending redirect and any branch accepted this cycle.
REQ-012 RedirectReady  input  1  fetch accepts the redirect this cycle.
REQ-013 Outputs: BranchReadyD (out, 1, block can accept a branch); RedirectValid (out, 1, redirect request); RedirectPC (out, 32, target); TakenCnt (out, CNT_W, taken branches); NotTakenCnt (out, CNT_W, not-taken branches).

Function
REQ-014 BranchOpD SHALL decode as follows, with any other value invalid:
- 000 none (never taken)
- 001 BEQ (Rs==Rt)
- 010 BNE (Rs!=Rt)
- 011 BGEZ (Rs[31]==0)
- 100 BGTZ (Rs[31]==0 and Rs!=0)
- 101 BLEZ (Rs[31]==1 or Rs==0)
- 110 BLTZ (Rs[31]==1)
- 111 always taken
REQ-015 Target SHALL be PCPlus4D + SignImmD_shift2, 32-bit, carry discarded; wrap-around is not an error.
REQ-016 FSM states SHALL be IDLE and PENDING only.
REQ-017 BranchReadyD SHALL be combinational: 1 when state==IDLE, or when state==PENDING and RedirectReady==1.
REQ-018 A branch SHALL be accepted when BranchValidD && BranchReadyD && !FlushD && BranchOpD!=000.
REQ-019 On acceptance with the condition true: next state SHALL be PENDING, RedirectPC SHALL be loaded with the target, and TakenCnt SHALL be incremented.
REQ-020 On acceptance with the condition false: next state SHALL be IDLE, RedirectPC SHALL be held, and NotTakenCnt SHALL be incremented.
REQ-021 Latency SHALL be exactly 1 cycle from acceptance to RedirectValid=1.
REQ-022 RedirectValid SHALL equal (state==PENDING) and SHALL be registered, with no combinational path from any input.
REQ-023 While in PENDING with RedirectReady==0, RedirectValid and RedirectPC SHALL hold stable.
REQ-024 In PENDING with RedirectReady==1 and no acceptance, the next state SHALL be IDLE.
REQ-025 In PENDING with RedirectReady==1 and a simultaneous acceptance, REQ-019/REQ-020 SHALL apply, allowing back-to-back redirects with no bubble.
REQ-026 FlushD SHALL take priority over everything: next state SHALL be IDLE, no acceptance occurs, and counters SHALL not change.
REQ-027 A flush coinciding with RedirectReady==1 SHALL be treated as a plain flush.
REQ-028 Counters SHALL wrap from 2^CNT_W-1 to 0 without saturating.
REQ-029 BranchValidD with BranchOpD==000 SHALL be ignored: no state change and no count.
REQ-030 When BranchValidD==0, RsValD, RtValD, PCPlus4D and SignImmD_shift2 SHALL be don't-care with no state effect.

Reset
REQ-031 On reset, the state SHALL be IDLE, RedirectValid SHALL be 0, RedirectPC SHALL be 32'h0, TakenCnt SHALL be 0, and NotTakenCnt SHALL be 0.
REQ-032 Reset SHALL override FlushD and any acceptance in the same cycle.
REQ-033 Reset asserted while PENDING SHALL drop RedirectValid at the next edge.
REQ-034 BranchReadyD SHALL be 1 in the cycle after reset.

Verification
REQ-035 BEQ hit: Op=001, Rs=Rt=5, PCPlus4D=0x1000_0004, SignImmD_shift2=0x0000_0010 -> next cycle RedirectValid=1, RedirectPC=0x1000_0014, TakenCnt=1.
REQ-036 Negative offset and wrap: Op=111, PCPlus4D=0x0000_0004, SignImmD_shift2=0xFFFF_FFF0 -> RedirectPC=0xFFFF_FFF4.
REQ-037 Backpressure: hold RedirectReady=0 for 3 cycles while PENDING -> RedirectValid and RedirectPC stable and BranchReadyD=0; then RedirectReady=1 with a new BNE having Rs=1, Rt=2 -> PENDING again with the new target and no idle cycle.
REQ-038 Not-taken plus condition boundaries:
- BGTZ, Rs=0 -> not taken, NotTakenCnt+1, RedirectValid stays 0
- BLEZ, Rs=0 -> taken
- BLTZ, Rs=0x8000_0000 -> taken
REQ-039 Flush: FlushD=1 while PENDING and a taken branch is presented -> next cycle IDLE, RedirectValid=0, counters unchanged.
REQ-040 Counter wrap and reset: with CNT_W=2, 5 taken branches -> TakenCnt=1; reset pulsed mid-PENDING -> all outputs return to their REQ-031 values at the next edge.
